sha3_round_sequencer: RTL
=========================

Name: sha3_round_sequencer

Overview:
- Iteration controller that owns one iterable SHA3 round unit (THETA, RHO+PI, CHI, IOTA(i) per pass, fixed latency L, sample/ogood/oround handshake).
- Accepts a 1600-bit Keccak state and issues it to the round unit 24 times, feeding each result back with the next round index.
- Presents the final permuted state with a one-cycle good pulse.
- Sits between the scanner's nonce/state feeder and the hash comparator.

Parameters:
- ROUNDS, 24, number of round passes; legal range 1..24.
- WATCHDOG, 64, maximum cycles spent waiting for rnd_good after a sample before a timeout is declared; must exceed round latency L.
- CHECK_ROUND, 1, when 1, compare rnd_oround against the expected index and flag a mismatch.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; honoured only when busy=0.
- isa,isb,isc,isd,ise  in  64x5 each  input state rows.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- rnd_index  out  5  round index driven to the round unit.
- rnd_sample  out  1  one-cycle issue strobe to the round unit.
- rnd_sa..rnd_se  out  64x5 each  working state driven to the round unit.
- rnd_oa..rnd_oe  in  64x5 each  state returned by the round unit.
- rnd_oround  in  5  round index returned by the round unit.
- rnd_good  in  1  result-valid strobe from the round unit.
- osa,osb,osc,osd,ose  out  64x5 each  final state, held until the next accepted start.
- ogood  out  1  one-cycle result strobe.
- oerr  out  2  bit0 = round mismatch, bit1 = timeout; sticky, cleared on an accepted start.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including the working registers, rnd_index, the os* rows, oerr, busy and strobes; counters cleared. Mid-operation reset aborts with no ogood and no carry-over.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 latches is* into the working registers, sets rnd=0, clears oerr and moves to ISSUE.
  - start=0 stays in IDLE.
- ISSUE (exactly 1 cycle): rnd_sample=1, rnd_index=rnd, rnd_s*=working registers; next WAIT; watchdog counter cleared to 0.
- WAIT:
  - rnd_sample=0; rnd_s* holds its value.
  - Watchdog counts up by 1 per cycle.
  - On rnd_good=1: capture rnd_o* into the working registers.
  - If CHECK_ROUND and rnd_oround != rnd: set oerr[0] and go to DONE.
  - Else if rnd == ROUNDS-1: go to DONE.
  - Else: rnd <= rnd+1 and go to ISSUE.
  - If the watchdog reaches WATCHDOG-1 with rnd_good=0: set oerr[1] and go to DONE. The working state at that point is the last captured state.
  - rnd_good and the watchdog expiry in the same cycle: rnd_good wins.
- DONE (1 cycle): os* <= working registers, ogood=1, busy=1; next IDLE.
- start while busy=1 is ignored. No queueing.
- rnd_good outside WAIT is ignored, with no state change.
- Latency: with round latency L (rnd_good L cycles after rnd_sample), each round takes L+1 cycles. ogood is asserted ROUNDS*(L+1)+1 cycles after the start edge. Back-to-back throughput is one permutation per ROUNDS*(L+1)+2 cycles.
- rnd counter is 5 bits and never wraps, because ROUNDS<=24.
- No arithmetic on state data; this block only muxes and registers it.

Test Plan:
- Bench round model: behavioural Keccak round, L=3. Apply all-zero state and pulse start -> ogood exactly 97 cycles after start; osa[0]=0xF1258F7940E1DDE7; oerr=0; exactly 24 rnd_sample pulses, with indices 0..23 in order.
- Pulse start again 10 cycles into a run with a different state -> ignored; result identical to the first scenario; busy stays 1 throughout.
- Round model returns rnd_oround=7 on the pass where rnd=5 -> ogood one cycle after that rnd_good; oerr=2'b01; busy drops the following cycle.
- Round model stops responding after round 3 -> 63 cycles of WAIT, then ogood with oerr=2'b10; os* equals the state after round 3.
- Assert rst during WAIT of round 12 -> all outputs 0 immediately (asynchronously), with no ogood. A new start after release completes normally with the correct hash.
- Run two permutations back-to-back, with start in the cycle after ogood -> second ogood 98 cycles after the first; os* from the first run holds until the second DONE.

Source files
------------

// File: rtl/sha3_round_sequencer.sv
// Iteration controller for an iterable SHA3 round unit: issues a 1600-bit state
// ROUNDS times, feeds each result back, and presents the permuted state.
module sha3_round_sequencer #(
  parameter int ROUNDS      = 24,
  parameter int WATCHDOG    = 64,
  parameter int CHECK_ROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic             busy,
  output logic [4:0]       rnd_index,
  output logic             rnd_sample,
  output logic [4:0][63:0] rnd_sa,
  output logic [4:0][63:0] rnd_sb,
  output logic [4:0][63:0] rnd_sc,
  output logic [4:0][63:0] rnd_sd,
  output logic [4:0][63:0] rnd_se,
  input  logic [4:0][63:0] rnd_oa,
  input  logic [4:0][63:0] rnd_ob,
  input  logic [4:0][63:0] rnd_oc,
  input  logic [4:0][63:0] rnd_od,
  input  logic [4:0][63:0] rnd_oe,
  input  logic [4:0]       rnd_oround,
  input  logic             rnd_good,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic             ogood,
  output logic [1:0]       oerr
);

  localparam int               WDW      = (WATCHDOG > 2) ? $clog2(WATCHDOG) : 1;
  localparam logic [WDW-1:0]   WD_LAST  = WDW'(WATCHDOG - 2);
  localparam logic [4:0]       RND_LAST = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                     state;
  logic [4:0]                 rnd;
  logic [WDW-1:0]             wd;
  logic [4:0][4:0][63:0]      work;
  logic [4:0][4:0][63:0]      os_q;
  logic [4:0][4:0][63:0]      in_rows;
  logic [4:0][4:0][63:0]      ret_rows;

  assign in_rows  = {ise, isd, isc, isb, isa};
  assign ret_rows = {rnd_oe, rnd_od, rnd_oc, rnd_ob, rnd_oa};

  // The working registers feed the round unit directly; they only change on
  // start or on rnd_good, so rnd_s* is stable throughout WAIT.
  assign rnd_index = rnd;
  assign rnd_sa    = work[0];
  assign rnd_sb    = work[1];
  assign rnd_sc    = work[2];
  assign rnd_sd    = work[3];
  assign rnd_se    = work[4];
  assign osa       = os_q[0];
  assign osb       = os_q[1];
  assign osc       = os_q[2];
  assign osd       = os_q[3];
  assign ose       = os_q[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rnd        <= '0;
      wd         <= '0;
      work       <= '0;
      os_q       <= '0;
      busy       <= 1'b0;
      rnd_sample <= 1'b0;
      ogood      <= 1'b0;
      oerr       <= '0;
    end else begin
      rnd_sample <= 1'b0;
      ogood      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work       <= in_rows;
            rnd        <= '0;
            oerr       <= '0;
            busy       <= 1'b1;
            rnd_sample <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + WDW'(1);
          // os*/ogood are loaded on entry to DONE so both are valid in that cycle.
          if (rnd_good) begin
            work <= ret_rows;
            if ((CHECK_ROUND != 0) && (rnd_oround != rnd)) begin
              oerr[0] <= 1'b1;
              os_q    <= ret_rows;
              ogood   <= 1'b1;
              state   <= DONE;
            end else if (rnd == RND_LAST) begin
              os_q  <= ret_rows;
              ogood <= 1'b1;
              state <= DONE;
            end else begin
              rnd        <= rnd + 5'd1;
              rnd_sample <= 1'b1;
              state      <= ISSUE;
            end
          end else if (wd == WD_LAST) begin
            oerr[1] <= 1'b1;
            os_q    <= work;
            ogood   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
